// File: rtl/mem_pkg.sv
// Shared definitions for the memory arbiter and the memory it drives.
package mem_pkg;

    localparam logic [1:0] sz_byte  = 2'd0;
    localparam logic [1:0] sz_word  = 2'd1;
    localparam logic [1:0] sz_4word = 2'd2;
    localparam logic [1:0] sz_8word = 2'd3;

    localparam int LINE_BEATS = 4;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } arb_state_t;

    // Only byte and word reach the memory; every other code becomes a word.
    function automatic logic [1:0] norm_size(input logic [1:0] size);
        return (size == sz_byte) ? sz_byte : sz_word;
    endfunction

endpackage

// File: rtl/mem_arbiter_rr_arb2.sv
// Two-input round-robin picker; bit 0 = fetch, bit 1 = data.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       take,
    output logic [1:0] grant
);

    logic last_data;

    always_comb begin
        grant = req;
        if (req == 2'b11) begin
            grant = last_data ? 2'b01 : 2'b10;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_data <= 1'b0;
        end else if (take && (grant != 2'b00)) begin
            last_data <= grant[1];
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates fetch and data ports onto the single-ported memory and splits
// fetch lines into consecutive word accesses.
module mem_arbiter
    import mem_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h8002_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    input  logic        i_line,
    output logic [31:0] i_rdata,
    output logic        i_rvalid,
    output logic        i_done,
    input  logic        d_req,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [1:0]  d_size,
    input  logic        d_rd_wr,
    output logic [31:0] d_rdata,
    output logic        d_done,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_data_in,
    output logic [1:0]  mem_access_size,
    output logic        mem_rd_wr,
    output logic        mem_enable,
    input  logic [31:0] mem_data_out,
    input  logic        mem_busy
);

    arb_state_t  state_q, state_d;
    logic [1:0]  grant;
    logic        port_data_q;
    logic [31:0] addr_q;
    logic [1:0]  size_q;
    logic        rd_wr_q;
    logic [31:0] wdata_q;
    logic [2:0]  beats_q;
    logic [31:0] i_rdata_q;
    logic [31:0] d_rdata_q;
    logic        last_beat;

    assign last_beat = (beats_q <= 3'd1);

    rr_arb2 u_rr_arb2 (
        .clk   (clk),
        .rst   (rst),
        .req   ({d_req, i_req}),
        .take  (state_q == IDLE),
        .grant (grant)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        mem_enable      = 1'b0;
        mem_addr        = '0;
        mem_data_in     = '0;
        mem_access_size = '0;
        mem_rd_wr       = 1'b0;
        i_rdata         = i_rdata_q;
        i_rvalid        = 1'b0;
        i_done          = 1'b0;
        d_rdata         = d_rdata_q;
        d_done          = 1'b0;
        case (state_q)
            IDLE: begin
                if (grant != 2'b00) begin
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                mem_enable      = 1'b1;
                mem_addr        = addr_q;
                mem_data_in     = wdata_q;
                mem_access_size = size_q;
                mem_rd_wr       = rd_wr_q;
                if (!mem_busy) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                state_d = last_beat ? IDLE : ACCESS;
                if (!port_data_q) begin
                    i_rdata  = mem_data_out;
                    i_rvalid = 1'b1;
                    i_done   = last_beat;
                end else begin
                    if (rd_wr_q) begin
                        d_rdata = mem_data_out;
                    end
                    d_done = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Request latch, line sequencing and read-data hold registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            port_data_q <= 1'b0;
            addr_q      <= '0;
            size_q      <= '0;
            rd_wr_q     <= 1'b0;
            wdata_q     <= '0;
            beats_q     <= '0;
            i_rdata_q   <= '0;
            d_rdata_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (grant[1]) begin
                        port_data_q <= 1'b1;
                        addr_q      <= d_addr;
                        size_q      <= norm_size(d_size);
                        rd_wr_q     <= d_rd_wr;
                        wdata_q     <= d_wdata;
                        beats_q     <= 3'd1;
                    end else if (grant[0]) begin
                        port_data_q <= 1'b0;
                        addr_q      <= i_addr & ~32'h3;
                        size_q      <= sz_word;
                        rd_wr_q     <= 1'b1;
                        wdata_q     <= '0;
                        beats_q     <= i_line ? 3'(LINE_BEATS) : 3'd1;
                    end
                end
                RESP: begin
                    if (!port_data_q) begin
                        i_rdata_q <= mem_data_out;
                    end else if (rd_wr_q) begin
                        d_rdata_q <= mem_data_out;
                    end
                    if (!last_beat) begin
                        addr_q  <= {addr_q[31:2] + 30'd1, 2'b00};
                        beats_q <= beats_q - 3'd1;
                    end else begin
                        beats_q <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomised self-checking bench for mem_arbiter with a behavioural memory.
module tb_mem_arbiter;
    import mem_pkg::*;

    localparam logic [31:0] BASE = 32'h8002_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_req, i_line, i_rvalid, i_done;
    logic [31:0] i_addr, i_rdata;
    logic        d_req, d_rd_wr, d_done;
    logic [31:0] d_addr, d_wdata, d_rdata;
    logic [1:0]  d_size;
    logic [31:0] mem_addr, mem_data_in, mem_data_out;
    logic [1:0]  mem_access_size;
    logic        mem_rd_wr, mem_enable, mem_busy;

    int total = 0;
    int bad = 0;
    int cyc = 0;

    logic [31:0] mem [0:255];
    logic [31:0] ref_mem [0:255];
    logic        pl_en;
    logic [7:0]  pl_idx;
    logic [31:0] pl_data;
    logic [31:0] exp_d_rdata;

    int          ib_cyc[$];
    logic [31:0] ib_data[$];
    logic        done_port[$];
    int          done_cyc[$];
    logic [31:0] dd_data[$];
    int          acc_cyc[$];
    logic [31:0] acc_addr[$];
    logic [1:0]  acc_size[$];
    logic        acc_rw[$];

    mem_arbiter #(.BASE_ADDR(BASE)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_line(i_line),
        .i_rdata(i_rdata), .i_rvalid(i_rvalid), .i_done(i_done),
        .d_req(d_req), .d_addr(d_addr), .d_wdata(d_wdata), .d_size(d_size),
        .d_rd_wr(d_rd_wr), .d_rdata(d_rdata), .d_done(d_done),
        .mem_addr(mem_addr), .mem_data_in(mem_data_in),
        .mem_access_size(mem_access_size), .mem_rd_wr(mem_rd_wr),
        .mem_enable(mem_enable), .mem_data_out(mem_data_out), .mem_busy(mem_busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Memory: registered read data, big-endian byte lanes, stalls while busy.
    always @(posedge clk) begin
        if (pl_en) begin
            mem[pl_idx] <= pl_data;
        end else if (mem_enable && !mem_busy) begin
            if (mem_rd_wr) mem_data_out <= mem[mem_addr[9:2]];
            else if (mem_access_size == sz_byte)
                mem[mem_addr[9:2]][(3 - int'(mem_addr[1:0])) * 8 +: 8] <= mem_data_in[7:0];
            else mem[mem_addr[9:2]] <= mem_data_in;
        end
    end

    always @(posedge clk) begin
        if (mem_enable === 1'b1 && mem_busy === 1'b0) begin
            acc_cyc.push_back(cyc);
            acc_addr.push_back(mem_addr);
            acc_size.push_back(mem_access_size);
            acc_rw.push_back(mem_rd_wr);
        end
    end

    always @(negedge clk) begin
        if (i_rvalid === 1'b1) begin
            ib_cyc.push_back(cyc);
            ib_data.push_back(i_rdata);
        end
        if (i_done === 1'b1) begin
            done_port.push_back(1'b0);
            done_cyc.push_back(cyc);
        end
        if (d_done === 1'b1) begin
            done_port.push_back(1'b1);
            done_cyc.push_back(cyc);
            dd_data.push_back(d_rdata);
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic preload(input int idx, input logic [31:0] data);
        @(negedge clk);
        pl_en = 1'b1;
        pl_idx = 8'(idx);
        pl_data = data;
        ref_mem[idx] = data;
        @(negedge clk);
        pl_en = 1'b0;
    endtask

    task automatic ref_write(input int idx, input int lane, input bit is_byte, input logic [31:0] wd);
        if (is_byte) ref_mem[idx][(3 - lane) * 8 +: 8] = wd[7:0];
        else ref_mem[idx] = wd;
    endtask

    // Runs until the wanted done pulses arrive, dropping each req after its done.
    task automatic run_until(input bit want_i, input bit want_d, input bit rnd_busy,
                             input int budget, output int i_at, output int d_at);
        i_at = -1;
        d_at = -1;
        for (int k = 0; k < budget; k++) begin
            @(negedge clk);
            if (i_done === 1'b1 && i_at < 0) begin i_at = cyc; i_req = 1'b0; end
            if (d_done === 1'b1 && d_at < 0) begin d_at = cyc; d_req = 1'b0; end
            mem_busy = rnd_busy ? 1'($urandom_range(0, 3) == 0) : 1'b0;
            if ((!want_i || i_at >= 0) && (!want_d || d_at >= 0)) break;
        end
        mem_busy = 1'b0;
    endtask

    task automatic test_reset();
        tick();
        total++;
        if ({i_rdata, i_rvalid, i_done, d_rdata, d_done, mem_addr, mem_data_in,
             mem_access_size, mem_rd_wr, mem_enable} !== '0) begin
            bad++;
            $display("FAIL reset_outputs: got i_rdata=%h d_rdata=%h mem_en=%b mem_addr=%h want all 0",
                     i_rdata, d_rdata, mem_enable, mem_addr);
        end
    endtask

    task automatic test_fetch_single();
        int s, ia, da, b0, a0;
        preload(0, 32'hDEAD_BEEF);
        b0 = ib_data.size(); a0 = acc_addr.size();
        s = cyc;
        i_req = 1'b1; i_addr = BASE + 32'h2; i_line = 1'b0;
        run_until(1'b1, 1'b0, 1'b0, 20, ia, da);
        total++; if (ia - s !== 2) begin bad++; $display("FAIL single_latency: got %0d want 2", ia - s); end
        tick();
        total++; if (ib_data.size() - b0 !== 1) begin bad++; $display("FAIL single_beats: got %0d want 1", ib_data.size() - b0); end
        total++; if (ib_data.size() > b0 && ib_data[b0] !== 32'hDEAD_BEEF) begin bad++; $display("FAIL single_data: got %h want deadbeef", ib_data[b0]); end
        total++; if (acc_addr.size() <= a0 || acc_addr[a0] !== BASE) begin bad++; $display("FAIL single_addr: got %0d accesses want addr %h", acc_addr.size() - a0, BASE); end
        total++; if (i_rdata !== 32'hDEAD_BEEF || i_rvalid !== 1'b0) begin bad++; $display("FAIL single_hold: got %h/%b want deadbeef/0", i_rdata, i_rvalid); end
        total++; if (mem_enable !== 1'b0 || mem_addr !== 32'h0) begin bad++; $display("FAIL idle_mem_zero: got en=%b addr=%h want 0/0", mem_enable, mem_addr); end
    endtask

    task automatic test_byte_write_read();
        int s, ia, da, q0, a0;
        logic [31:0] wd;
        wd = {$urandom_range(0, 32'hFFFFFF) & 32'hFFFFFF, 8'h00} | 32'hAB;
        q0 = dd_data.size(); a0 = acc_addr.size();
        s = cyc;
        d_req = 1'b1; d_addr = BASE + 32'h5; d_wdata = wd; d_size = sz_byte; d_rd_wr = 1'b0;
        ref_write(1, 1, 1'b1, wd);
        run_until(1'b0, 1'b1, 1'b0, 20, ia, da);
        tick();
        total++; if (da - s !== 2) begin bad++; $display("FAIL write_latency: got %0d want 2", da - s); end
        total++; if (dd_data.size() <= q0 || dd_data[q0] !== exp_d_rdata) begin bad++; $display("FAIL write_rdata_unchanged: got %h want %h", d_rdata, exp_d_rdata); end
        total++; if (acc_size.size() <= a0 || acc_size[a0] !== sz_byte || acc_rw[a0] !== 1'b0 || acc_addr[a0] !== BASE + 32'h5) begin bad++; $display("FAIL write_access: got %0d accesses want byte write at %h", acc_size.size() - a0, BASE + 32'h5); end
        q0 = dd_data.size(); a0 = acc_addr.size();
        s = cyc;
        d_req = 1'b1; d_addr = BASE + 32'h4; d_size = sz_word; d_rd_wr = 1'b1;
        run_until(1'b0, 1'b1, 1'b0, 20, ia, da);
        tick();
        exp_d_rdata = ref_mem[1];
        total++; if (da - s !== 2) begin bad++; $display("FAIL read_latency: got %0d want 2", da - s); end
        total++; if (dd_data.size() <= q0 || dd_data[q0] !== exp_d_rdata) begin bad++; $display("FAIL read_after_byte: got %h want %h", d_rdata, exp_d_rdata); end
        total++; if (d_rdata[23:16] !== 8'hAB) begin bad++; $display("FAIL byte_lane1: got %h want ab", d_rdata[23:16]); end
        total++; if (acc_size.size() <= a0 || acc_size[a0] !== sz_word) begin bad++; $display("FAIL read_size: got %0d accesses want word", acc_size.size() - a0); end
    endtask

    task automatic test_fetch_line();
        int s, ia, da, b0, a0, p0;
        for (int k = 0; k < 4; k++) preload(4 + k, 32'(k + 1));
        b0 = ib_data.size(); a0 = acc_addr.size(); p0 = done_port.size();
        s = cyc;
        i_req = 1'b1; i_addr = BASE + 32'h10; i_line = 1'b1;
        run_until(1'b1, 1'b0, 1'b0, 30, ia, da);
        tick();
        total++; if (ia - s !== 8) begin bad++; $display("FAIL line_done_cycle: got %0d want 8", ia - s); end
        total++; if (ib_data.size() - b0 !== 4 || acc_addr.size() - a0 !== 4) begin bad++; $display("FAIL line_beats: got %0d/%0d want 4/4", ib_data.size() - b0, acc_addr.size() - a0); end
        total++; if (done_port.size() - p0 !== 1) begin bad++; $display("FAIL line_single_done: got %0d want 1", done_port.size() - p0); end
        if (ib_data.size() - b0 == 4 && acc_addr.size() - a0 == 4) begin
            for (int k = 0; k < 4; k++) begin
                total++;
                if (ib_cyc[b0 + k] - s !== 2 + 2 * k || ib_data[b0 + k] !== 32'(k + 1) ||
                    acc_addr[a0 + k] !== BASE + 32'h10 + 32'(4 * k) || acc_size[a0 + k] !== sz_word || acc_rw[a0 + k] !== 1'b1) begin
                    bad++;
                    $display("FAIL line_beat%0d: got cyc=%0d data=%h addr=%h want cyc=%0d data=%h addr=%h", k,
                             ib_cyc[b0 + k] - s, ib_data[b0 + k], acc_addr[a0 + k], 2 + 2 * k, k + 1, BASE + 32'h10 + 32'(4 * k));
                end
            end
        end
    endtask

    task automatic test_tie_from_reset();
        int s, p0, q0, b0;
        bit last_data, win;
        rst = 1'b1; tick(); rst = 1'b0;
        p0 = done_port.size(); q0 = dd_data.size(); b0 = ib_data.size();
        s = cyc;
        d_req = 1'b1; d_addr = BASE + 32'h40; d_size = sz_word; d_rd_wr = 1'b1;
        i_req = 1'b1; i_addr = BASE + 32'h80; i_line = 1'b0;
        for (int k = 0; k < 80; k++) begin
            tick();
            if (done_port.size() - p0 >= 4) break;
        end
        i_req = 1'b0; d_req = 1'b0;
        tick(); tick();
        exp_d_rdata = ref_mem[16];
        total++; if (done_port.size() - p0 !== 4) begin bad++; $display("FAIL tie_done_count: got %0d want 4", done_port.size() - p0); end
        last_data = 1'b0;
        for (int k = 0; k < 4 && p0 + k < done_port.size(); k++) begin
            win = !last_data;
            last_data = win;
            total++;
            if (done_port[p0 + k] !== win || done_cyc[p0 + k] - s !== 2 + 3 * k) begin
                bad++;
                $display("FAIL tie_order%0d: got port=%b cyc=%0d want port=%b cyc=%0d", k,
                         done_port[p0 + k], done_cyc[p0 + k] - s, win, 2 + 3 * k);
            end
        end
        total++; if (dd_data.size() <= q0 || dd_data[q0] !== ref_mem[16]) begin bad++; $display("FAIL tie_d_data: got %h want %h", d_rdata, ref_mem[16]); end
        total++; if (ib_data.size() <= b0 || ib_data[b0] !== ref_mem[32]) begin bad++; $display("FAIL tie_i_data: got %h want %h", i_rdata, ref_mem[32]); end
    endtask

    task automatic test_data_mid_line();
        int s, ia, da, a0, q0, dacc;
        a0 = acc_addr.size(); q0 = dd_data.size();
        s = cyc;
        i_req = 1'b1; i_addr = BASE + 32'h100; i_line = 1'b1;
        tick(); tick(); tick();
        d_req = 1'b1; d_addr = BASE + 32'h200; d_size = sz_word; d_rd_wr = 1'b1;
        run_until(1'b1, 1'b1, 1'b0, 60, ia, da);
        tick();
        exp_d_rdata = ref_mem[128];
        dacc = -1;
        for (int k = a0; k < acc_addr.size(); k++) if (acc_addr[k] == BASE + 32'h200 && dacc < 0) dacc = acc_cyc[k] - s;
        total++; if (ia - s !== 8) begin bad++; $display("FAIL mid_i_done: got %0d want 8", ia - s); end
        total++; if (da - s !== 11) begin bad++; $display("FAIL mid_d_done: got %0d want 11", da - s); end
        total++; if (dacc !== 10) begin bad++; $display("FAIL mid_d_access: got %0d want 10", dacc); end
        total++; if (dd_data.size() <= q0 || dd_data[q0] !== ref_mem[128]) begin bad++; $display("FAIL mid_d_data: got %h want %h", d_rdata, ref_mem[128]); end
    endtask

    task automatic test_reset_mid_line();
        int s, ia, da, b0, p0;
        b0 = ib_data.size(); p0 = done_port.size();
        s = cyc;
        i_req = 1'b1; i_addr = BASE + 32'h20; i_line = 1'b1;
        tick(); tick(); tick();
        total++; if (mem_enable !== 1'b1 || mem_addr !== BASE + 32'h24) begin bad++; $display("FAIL beat2_access: got en=%b addr=%h want 1/%h", mem_enable, mem_addr, BASE + 32'h24); end
        rst = 1'b1;
        #1;
        total++;
        if ({i_rdata, i_rvalid, i_done, d_rdata, d_done, mem_addr, mem_data_in,
             mem_access_size, mem_rd_wr, mem_enable} !== '0) begin
            bad++;
            $display("FAIL async_reset: got en=%b addr=%h i_rdata=%h d_rdata=%h want all 0", mem_enable, mem_addr, i_rdata, d_rdata);
        end
        i_req = 1'b0;
        tick(); tick();
        rst = 1'b0;
        repeat (6) tick();
        exp_d_rdata = '0;
        total++; if (done_port.size() - p0 !== 0 || ib_data.size() - b0 !== 1) begin bad++; $display("FAIL aborted_line: got dones=%0d beats=%0d want 0/1", done_port.size() - p0, ib_data.size() - b0); end
        b0 = ib_data.size();
        s = cyc;
        i_req = 1'b1; i_addr = BASE + 32'h24; i_line = 1'b0;
        run_until(1'b1, 1'b0, 1'b0, 20, ia, da);
        tick();
        total++; if (ia - s !== 2 || ib_data.size() <= b0 || ib_data[b0] !== ref_mem[9]) begin bad++; $display("FAIL after_reset_fetch: got lat=%0d data=%h want 2/%h", ia - s, i_rdata, ref_mem[9]); end
    endtask

    task automatic test_random();
        int ia, da, b0, q0, mode, fidx, didx, dlane, nb;
        bit line, drd, dbyte, do_i, do_d, last_data, win;
        logic [1:0] dsz;
        logic [31:0] dwd, exp_rd;
        rst = 1'b1; tick(); rst = 1'b0;
        exp_d_rdata = '0;
        last_data = 1'b0;
        for (int r = 0; r < 40; r++) begin
            mode = $urandom_range(0, 2);
            do_i = (mode != 1);
            do_d = (mode != 0);
            fidx = $urandom_range(0, 60);
            line = 1'($urandom_range(0, 1));
            nb = line ? LINE_BEATS : 1;
            didx = 160 + $urandom_range(0, 63);
            dlane = $urandom_range(0, 3);
            dsz = 2'($urandom_range(0, 3));
            dbyte = (dsz == sz_byte);
            drd = 1'($urandom_range(0, 1));
            dwd = $urandom;
            exp_rd = exp_d_rdata;
            if (do_d && drd) exp_rd = ref_mem[didx];
            b0 = ib_data.size(); q0 = dd_data.size();
            if (do_i) begin i_req = 1'b1; i_addr = BASE + 32'(fidx * 4 + $urandom_range(0, 3)); i_line = line; end
            if (do_d) begin
                d_req = 1'b1; d_addr = BASE + 32'(didx * 4 + dlane); d_size = dsz; d_rd_wr = drd; d_wdata = dwd;
                if (!drd) ref_write(didx, dlane, dbyte, dwd);
            end
            run_until(do_i, do_d, 1'b1, 200, ia, da);
            tick();
            if (do_i) begin
                total++; if (ia < 0 || ib_data.size() - b0 !== nb) begin bad++; $display("FAIL rnd%0d_fetch: got done=%0d beats=%0d want beats=%0d", r, ia, ib_data.size() - b0, nb); end
                for (int k = 0; k < nb && b0 + k < ib_data.size(); k++) begin
                    total++; if (ib_data[b0 + k] !== ref_mem[fidx + k]) begin bad++; $display("FAIL rnd%0d_beat%0d: got %h want %h", r, k, ib_data[b0 + k], ref_mem[fidx + k]); end
                end
            end
            if (do_d) begin
                exp_d_rdata = exp_rd;
                total++; if (da < 0 || dd_data.size() <= q0 || dd_data[q0] !== exp_rd) begin bad++; $display("FAIL rnd%0d_data: got done=%0d rdata=%h want %h", r, da, d_rdata, exp_rd); end
            end
            if (do_i && do_d) begin
                win = !last_data;
                last_data = !win;
                total++;
                if (ia < 0 || da < 0 || (win ? (ia - da < 3) : (da - ia < 3))) begin
                    bad++;
                    $display("FAIL rnd%0d_order: got i_done=%0d d_done=%0d want %s first", r, ia, da, win ? "data" : "fetch");
                end
            end else begin
                last_data = do_d;
            end
        end
        // Data region readback confirms every write reached memory intact.
        for (int k = 160; k < 224; k += 9) begin
            b0 = dd_data.size();
            d_req = 1'b1; d_addr = BASE + 32'(k * 4); d_size = sz_word; d_rd_wr = 1'b1;
            run_until(1'b0, 1'b1, 1'b0, 20, ia, da);
            tick();
            exp_d_rdata = ref_mem[k];
            total++; if (dd_data.size() <= b0 || dd_data[b0] !== ref_mem[k]) begin bad++; $display("FAIL readback%0d: got %h want %h", k, d_rdata, ref_mem[k]); end
        end
    endtask

    initial begin
        rst = 1'b1;
        i_req = 1'b0; i_addr = '0; i_line = 1'b0;
        d_req = 1'b0; d_addr = '0; d_wdata = '0; d_size = '0; d_rd_wr = 1'b0;
        mem_busy = 1'b0; pl_en = 1'b0; pl_idx = '0; pl_data = '0;
        exp_d_rdata = '0;
        tick();
        for (int i = 0; i < 256; i++) preload(i, $urandom);
        test_reset();
        rst = 1'b0;
        tick();
        test_fetch_single();
        test_byte_write_read();
        test_fetch_line();
        test_tie_from_reset();
        test_data_mid_line();
        test_reset_mid_line();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
